// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
package fetch_pkg;

    // Sequencer states: reset hold, PC load, steady-state fetch, redirect drain
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: sequences PC updates, stalls and clears for the
// fetch PC register, and runs the request/ready handshake to instruction
// memory while arbitrating branch redirects against hazard stalls.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT,
    parameter logic        HIGH         = 1'b1,
    parameter logic        LOW          = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_CURRENT,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        HAZARD_STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    output logic [31:0] PC_NEXT,
    output logic        STALL_FETCH,
    output logic        CLEAR_FETCH,
    output logic        INSTR_VALID
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  redirect;
    logic [31:0]  redirect_nxt;
    logic [31:0]  target_aligned;
    logic [31:0]  pc_inc;

    // Branch targets are word-aligned; sequential PC wraps modulo 2^32
    assign target_aligned = BRANCH_TARGET & ~32'h0000_0003;
    assign pc_inc         = PC_CURRENT + 32'(INSTR_BYTES);

    // State and pending-redirect registers; reset aborts any open request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= BOOT;
            redirect <= '0;
        end else begin
            state    <= state_nxt;
            redirect <= redirect_nxt;
        end
    end

    // Next-state and output decode; memory address always tracks the
    // fetch PC, which is frozen whenever a request is waiting on READY
    always_comb begin
        state_nxt    = state;
        redirect_nxt = redirect;
        IMEM_REQ     = LOW;
        IMEM_ADDR    = PC_CURRENT;
        PC_NEXT      = BOOT_ADDRESS;
        STALL_FETCH  = HIGH;
        CLEAR_FETCH  = LOW;
        INSTR_VALID  = LOW;

        case (state)
            BOOT: begin
                CLEAR_FETCH = HIGH;
                state_nxt   = LOAD;
            end

            LOAD: begin
                STALL_FETCH = LOW;
                state_nxt   = FETCH;
            end

            FETCH: begin
                IMEM_REQ = HIGH;
                PC_NEXT  = PC_CURRENT;
                if (BRANCH_TAKEN && IMEM_READY) begin
                    // Squash the returning word and redirect at once
                    PC_NEXT     = target_aligned;
                    STALL_FETCH = LOW;
                end else if (BRANCH_TAKEN) begin
                    // Outstanding request must complete before redirecting
                    redirect_nxt = target_aligned;
                    state_nxt    = DRAIN;
                end else if (HAZARD_STALL) begin
                    // Hold PC; any READY this cycle is dropped and refetched
                    STALL_FETCH = HIGH;
                end else if (IMEM_READY) begin
                    INSTR_VALID = HIGH;
                    PC_NEXT     = pc_inc;
                    STALL_FETCH = LOW;
                end
            end

            DRAIN: begin
                IMEM_REQ = HIGH;
                PC_NEXT  = PC_CURRENT;
                if (BRANCH_TAKEN) begin
                    redirect_nxt = target_aligned;
                end
                if (IMEM_READY) begin
                    PC_NEXT     = BRANCH_TAKEN ? target_aligned : redirect;
                    STALL_FETCH = LOW;
                    state_nxt   = FETCH;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule
